// File: rtl/pacman_sprite_renderer_pkg.sv
// Shared constants and types for the Pac-Man sprite renderer.
// Imported by the renderer and by anything that drives its direction input.
package pacman_sprite_renderer_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int SPRITE_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_X    = 2'd1,
    DRAW      = 2'd2,
    LINE_DONE = 2'd3
  } state_t;

  // The 9-bit wrap-around difference keeps sprites near the bottom from aliasing onto lines 0..15.
  function automatic logic row_hit(input logic [8:0] line, input logic [7:0] top);
    logic [8:0] diff;
    diff = line - {1'b0, top};
    return diff < 9'(SPRITE_SIZE);
  endfunction

endpackage

// File: rtl/pacman_sprite_renderer.sv
// 16x16 sprite scan-out: matches the beam against a per-frame shadow position,
// walks an external bitmap ROM one column per pixel and registers the pixel onto gfx.
module pacman_sprite_renderer
  import pacman_sprite_renderer_pkg::*;
#(
  parameter int ANIM_PERIOD = 8,
  parameter int SCREEN_W    = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic [7:0] sprite_x,
  input  logic [7:0] sprite_y,
  input  logic [1:0] direction,
  input  logic       moving,
  output logic       rom_anim,
  output logic [1:0] rom_dir,
  output logic [3:0] rom_y,
  output logic [3:0] rom_x,
  input  logic       rom_bit,
  output logic       gfx,
  output logic       busy
);

  state_t      state_reg, state_next;
  logic [3:0]  col_reg, col_next;
  logic [7:0]  shadow_x_reg, shadow_y_reg;
  logic [1:0]  shadow_dir_reg;
  logic        anim_reg;
  logic [7:0]  count_reg;
  logic        gfx_reg;

  logic        frame_start;
  logic [7:0]  eff_x, eff_y;
  logic [8:0]  row_diff;
  logic        line_active;
  logic        next_line_active;
  logic        start_hit;
  logic        in_draw;
  logic        pixel_visible;

  assign frame_start = (hpos == 9'd0) && (vpos == 9'd0);

  // On the frame-start cycle the shadows are being loaded, so use the incoming values.
  assign eff_x = frame_start ? sprite_x : shadow_x_reg;
  assign eff_y = frame_start ? sprite_y : shadow_y_reg;

  assign row_diff         = vpos - {1'b0, eff_y};
  assign line_active      = row_diff < 9'(SPRITE_SIZE);
  assign next_line_active = row_hit(vpos + 9'd1, shadow_y_reg);

  // gfx is registered, so column 0 must be in DRAW on the cycle where hpos+1 == shadow_x;
  // the entry decision is therefore taken one cycle ahead. shadow_x==0 can never match.
  assign start_hit = ({1'b0, hpos} + 10'd2) == {2'b00, eff_x};

  assign in_draw       = (state_reg == DRAW);
  assign pixel_visible = ({1'b0, hpos} + 10'd1) < 10'(SCREEN_W);

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    if (hpos == 9'd0) begin
      col_next   = 4'd0;
      state_next = line_active ? (start_hit ? DRAW : WAIT_X) : IDLE;
    end else begin
      unique case (state_reg)
        IDLE: state_next = IDLE;
        WAIT_X: begin
          if (start_hit) begin
            state_next = DRAW;
            col_next   = 4'd0;
          end
        end
        DRAW: begin
          if (col_reg == 4'(SPRITE_SIZE - 1)) begin
            state_next = LINE_DONE;
            col_next   = 4'd0;
          end else begin
            col_next = col_reg + 4'd1;
          end
        end
        LINE_DONE: state_next = next_line_active ? WAIT_X : IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      col_reg        <= 4'd0;
      gfx_reg        <= 1'b0;
      shadow_x_reg   <= 8'd0;
      shadow_y_reg   <= 8'd0;
      shadow_dir_reg <= DIR_UP;
      anim_reg       <= 1'b0;
      count_reg      <= 8'd0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      gfx_reg   <= rom_bit & in_draw & display_on & pixel_visible;
      if (frame_start) begin
        shadow_x_reg   <= sprite_x;
        shadow_y_reg   <= sprite_y;
        shadow_dir_reg <= direction;
        if (moving) begin
          if (count_reg == 8'(ANIM_PERIOD - 1)) begin
            count_reg <= 8'd0;
            anim_reg  <= ~anim_reg;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
      end
    end
  end

  assign rom_anim = in_draw & anim_reg;
  assign rom_dir  = in_draw ? shadow_dir_reg : 2'd0;
  assign rom_y    = in_draw ? row_diff[3:0] : 4'd0;
  assign rom_x    = in_draw ? col_reg : 4'd0;
  assign gfx      = gfx_reg;
  assign busy     = in_draw;

endmodule

// File: tb/tb_pacman_sprite_renderer.sv
// Scoreboard bench for pacman_sprite_renderer: drives a short-frame sync pattern,
// models the visible sprite per pixel and compares gfx, busy and the ROM address every cycle.
`timescale 1ns/1ps
module tb_pacman_sprite_renderer;
  import pacman_sprite_renderer_pkg::*;

  localparam int H_TOTAL     = 272;
  localparam int H_DISP      = 264;
  localparam int SCREEN_W    = 256;
  localparam int ANIM_PERIOD = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] hpos, vpos;
  logic       display_on;
  logic [7:0] sprite_x, sprite_y;
  logic [1:0] direction;
  logic       moving;
  logic       rom_anim;
  logic [1:0] rom_dir;
  logic [3:0] rom_y, rom_x;
  logic       rom_bit;
  logic       gfx;
  logic       busy;

  always #5 clk = ~clk;

  pacman_sprite_renderer #(.ANIM_PERIOD(ANIM_PERIOD), .SCREEN_W(SCREEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .direction(direction), .moving(moving),
    .rom_anim(rom_anim), .rom_dir(rom_dir), .rom_y(rom_y), .rom_x(rom_x),
    .rom_bit(rom_bit), .gfx(gfx), .busy(busy)
  );

  // Bitmap that depends on every address field, so a wrong address shows up on gfx.
  function automatic logic rom_fn(input logic a, input logic [1:0] d, input logic [3:0] y, input logic [3:0] x);
    int s;
    s = int'(x) + 2 * int'(y) + 5 * int'(d) + 7 * int'(a);
    return (s % 3) != 0;
  endfunction

  assign rom_bit = rom_fn(rom_anim, rom_dir, rom_y, rom_x);

  typedef struct packed {
    logic        gfx;
    logic        busy;
    logic [10:0] rom;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;

  // Model of the frame-latched sprite state.
  int         m_sx, m_sy, m_cnt;
  logic [1:0] m_dir;
  logic       m_anim;

  int   rst_line = -1, rst_h = -1;
  int   probe_line = 50, probe_busy = 0;
  logic probe_anim = 1'b0;
  int   frame_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int rd, col;
    e  = '0;
    rd = (v - m_sy) & 511;
    if (rd < 16 && m_sx >= 2) begin
      col = h - m_sx + 1;
      if (col >= 0 && col <= 15) begin
        e.busy = 1'b1;
        e.rom  = {m_anim, m_dir, 4'(rd), 4'(col)};
      end
      col = h - m_sx;
      if (col >= 0 && col <= 15 && h < SCREEN_W)
        e.gfx = rom_fn(m_anim, m_dir, 4'(rd), 4'(col));
    end
    return e;
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_dir = 2'd0; m_anim = 1'b0; m_cnt = 0;
  endtask

  task automatic run_line(input int v);
    exp_t e;
    for (int h = 0; h < H_TOTAL; h++) begin
      @(posedge clk); #1;
      reset_n    = 1'b1;
      hpos       = 9'(h);
      vpos       = 9'(v);
      display_on = (h < H_DISP) && (v < 256);
      if (h == 0 && v == 0) begin
        m_sx = int'(sprite_x); m_sy = int'(sprite_y); m_dir = direction;
        if (moving) begin
          if (m_cnt == ANIM_PERIOD - 1) begin m_cnt = 0; m_anim = ~m_anim; end
          else m_cnt++;
        end
      end
      if (v == rst_line && h == rst_h) begin
        reset_n = 1'b0;
        #1;
        check($sformatf("rst_gfx@%0d,%0d", v, h), gfx, 0);
        check($sformatf("rst_busy@%0d,%0d", v, h), busy, 0);
        model_reset();
      end
      sb_q.push_back(model(h, v));
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("gfx@%0d,%0d", v, h), gfx, e.gfx);
      check($sformatf("busy@%0d,%0d", v, h), busy, e.busy);
      check($sformatf("rom@%0d,%0d", v, h), {rom_anim, rom_dir, rom_y, rom_x}, e.rom);
      if (v == probe_line && busy) begin
        probe_busy++;
        probe_anim = rom_anim;
      end
    end
  endtask

  task automatic run_lines(input int first, input int last);
    for (int v = first; v <= last; v++) run_line(v);
  endtask

  task automatic run_frame(input int first, input int last);
    probe_busy = 0;
    run_line(0);
    run_lines(first, last);
    frame_no++;
    $display("frame %0d lines 0,%0d..%0d sprite=(%0d,%0d) dir=%0d anim=%0d busy_on_%0d=%0d",
             frame_no, first, last, m_sx, m_sy, m_dir, m_anim, probe_line, probe_busy);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; hpos = 9'd300; vpos = 9'd300; display_on = 1'b0;
    sprite_x = 8'd100; sprite_y = 8'd50; direction = DIR_RIGHT; moving = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gfx", gfx, 0);
    check("reset_busy", busy, 0);
    check("reset_rom", {rom_anim, rom_dir, rom_y, rom_x}, 0);

    // Basic draw at (100,50).
    probe_line = 50;
    run_frame(48, 67);
    check("busy_len_x100", probe_busy, 16);

    // Animation toggles every ANIM_PERIOD frame starts while moving.
    moving = 1'b1;
    for (int f = 1; f <= 24; f++) begin
      run_frame(49, 51);
      if (f == 7)  check("anim_fs7", probe_anim, 0);
      if (f == 8)  check("anim_fs8", probe_anim, 1);
      if (f == 15) check("anim_fs15", probe_anim, 1);
      if (f == 16) check("anim_fs16", probe_anim, 0);
      if (f == 24) check("anim_fs24", probe_anim, 1);
    end
    moving = 1'b0;
    for (int f = 0; f < 5; f++) begin
      run_frame(49, 51);
      check("anim_frozen", probe_anim, 1);
    end

    // Mid-frame position change takes effect only at the next frame.
    probe_busy = 0;
    run_line(0);
    run_lines(48, 54);
    sprite_x = 8'd120;
    run_lines(55, 67);
    frame_no++;
    $display("frame %0d sprite_x changed to 120 at line 55 busy_on_50=%0d", frame_no, probe_busy);
    check("busy_len_tear", probe_busy, 16);
    run_frame(48, 67);
    check("busy_len_x120", probe_busy, 16);

    // Right-edge clipping.
    sprite_x = 8'd250;
    run_frame(49, 52);
    check("busy_len_x250", probe_busy, 16);

    // Bottom clipping with no alias onto the top lines.
    sprite_x = 8'd100; sprite_y = 8'd250; probe_line = 250;
    run_frame(248, 255);
    check("busy_len_y250", probe_busy, 16);
    probe_line = 5;
    run_frame(1, 11);
    check("busy_wrap_y250", probe_busy, 0);

    // sprite_x == 0 never draws.
    sprite_x = 8'd0; sprite_y = 8'd50; probe_line = 55;
    run_frame(48, 67);
    check("busy_x0", probe_busy, 0);

    // Reset pulse mid-sprite, then a normal frame.
    sprite_x = 8'd100; probe_line = 50;
    rst_line = 52; rst_h = 105;
    run_frame(48, 67);
    rst_line = -1; rst_h = -1;
    run_frame(48, 67);
    check("busy_after_reset", probe_busy, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
